// File: rtl/ascon_perm_responder.sv
// ascon_perm_responder: iterated Ascon permutation, one round per clock, with a one-cycle ready pulse.
// Ports: clk; rst_n (async active-low); permutation_start (sampled while idle);
//        P_in/rounds (request); P_out (state register); permutation_ready (done pulse); busy.
module ascon_perm_responder #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         permutation_start,
  input  logic [319:0] P_in,
  input  logic [4:0]   rounds,
  output logic [319:0] P_out,
  output logic         permutation_ready,
  output logic         busy
);
  localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);
  logic [319:0] st;
  logic [3:0]   ctr;
  logic [3:0]   a_eff;
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [319:0] rnd(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, y0, y1, y2, y3, y4;
    x0 = s[319:256];
    x1 = s[255:192];
    // round constant bytes run f0, e1, d2, ...: high nibble counts down as the low nibble counts up
    x2 = s[191:128] ^ {56'd0, 4'hf - i, i};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    y0 = x0 ^ (~x1 & x2);
    y1 = x1 ^ (~x2 & x3);
    y2 = x2 ^ (~x3 & x4);
    y3 = x3 ^ (~x4 & x0);
    y4 = x4 ^ (~x0 & x1);
    y1 = y1 ^ y0;
    y0 = y0 ^ y4;
    y3 = y3 ^ y2;
    y2 = ~y2;
    return {y0 ^ rotr(y0, 19) ^ rotr(y0, 28),
            y1 ^ rotr(y1, 61) ^ rotr(y1, 39),
            y2 ^ rotr(y2, 1)  ^ rotr(y2, 6),
            y3 ^ rotr(y3, 10) ^ rotr(y3, 17),
            y4 ^ rotr(y4, 7)  ^ rotr(y4, 41)};
  endfunction
  assign a_eff = (rounds > MAX_R) ? MAX_R[3:0] : rounds[3:0];
  assign P_out = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st                <= '0;
      ctr               <= '0;
      busy              <= 1'b0;
      permutation_ready <= 1'b0;
    end else begin
      permutation_ready <= 1'b0;
      if (busy) begin
        // counting down from a' means p6 uses the last six constants, matching Ascon
        st  <= rnd(st, 4'd12 - ctr);
        ctr <= ctr - 4'd1;
        if (ctr == 4'd1) begin
          busy              <= 1'b0;
          permutation_ready <= 1'b1;
        end
      end else if (permutation_start) begin
        st <= P_in;
        if (a_eff == 4'd0) permutation_ready <= 1'b1;
        else begin
          ctr  <= a_eff;
          busy <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ascon_perm_responder.sv
// tb_ascon_perm_responder: randomized self-checking bench against a word-array Ascon reference model.
module tb_ascon_perm_responder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         permutation_start = 1'b0;
  logic [319:0] P_in = '0;
  logic [4:0]   rounds = '0;
  logic [319:0] P_out;
  logic         permutation_ready;
  logic         busy;
  int checks = 0;
  int errors = 0;
  localparam logic [319:0] IV_IN  = {64'h00400c0000000000, 256'd0};
  localparam logic [319:0] IV_OUT = {64'hb57e273b814cd416, 64'h2b51042562ae2420, 64'h66a3a7768ddf2218,
                                     64'h5aad0a7a8153650c, 64'h4f3e0e32539493b6};
  ascon_perm_responder dut (
    .clk(clk), .rst_n(rst_n), .permutation_start(permutation_start), .P_in(P_in),
    .rounds(rounds), .P_out(P_out), .permutation_ready(permutation_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction
  function automatic logic [319:0] model(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [7:0]  c [12];
    int ra [5];
    int rb [5];
    int a;
    logic [319:0] o;
    c  = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    a  = (r > 12) ? 12 : r;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64 * k -: 64];
    for (int i = 12 - a; i < 12; i++) begin
      x[2] ^= {56'd0, c[i]};
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      for (int k = 0; k < 5; k++) x[k] = x[k] ^ rotr(x[k], ra[k]) ^ rotr(x[k], rb[k]);
    end
    for (int k = 0; k < 5; k++) o[319 - 64 * k -: 64] = x[k];
    return o;
  endfunction
  function automatic logic [319:0] rand_state();
    logic [319:0] p = '0;
    for (int j = 0; j < 10; j++) p = {p[287:0], 32'($urandom)};
    return p;
  endfunction
  // caller must be just after an edge; request is accepted at the next rising edge
  task automatic issue(input logic [319:0] p, input logic [4:0] r);
    permutation_start = 1'b1;
    P_in = p;
    rounds = r;
    @(posedge clk);
    #1 permutation_start = 1'b0;
  endtask
  // returns the number of rising edges after the accept edge until ready is seen
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!permutation_ready && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!permutation_ready) chk("ready_timeout", 320'(permutation_ready), 320'd1);
  endtask
  initial begin
    int lat, pulses, falls, rdy_cyc;
    logic pb;
    logic [319:0] p, p2, got;
    logic [4:0] r;
    #12;
    chk("rst_pout", P_out, '0);
    chk("rst_busy", 320'(busy), 320'd0);
    chk("rst_ready", 320'(permutation_ready), 320'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    issue(IV_IN, 5'd12);
    chk("iv_busy", 320'(busy), 320'd1);
    wait_ready(lat);
    chk("iv_lat", 320'(lat), 320'd12);
    chk("iv_out", P_out, IV_OUT);
    @(posedge clk);
    #1 chk("iv_pulse_width", 320'(permutation_ready), 320'd0);
    chk("iv_hold", P_out, IV_OUT);
    p = rand_state();
    @(negedge clk);
    issue(p, 5'd0);
    chk("pass_busy", 320'(busy), 320'd0);
    wait_ready(lat);
    chk("pass_lat", 320'(lat), 320'd0);
    chk("pass_out", P_out, p);
    @(negedge clk);
    issue(IV_IN, 5'd15);
    wait_ready(lat);
    chk("clamp_lat", 320'(lat), 320'd12);
    chk("clamp_out", P_out, IV_OUT);
    @(negedge clk);
    issue(IV_IN, 5'd12);
    pulses = 0; falls = 0; rdy_cyc = 0; pb = busy; got = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      if (permutation_ready) begin pulses++; rdy_cyc = cyc; got = P_out; end
      if (pb && !busy) falls++;
      pb = busy;
      permutation_start = (cyc == 3 || cyc == 7);
      if (permutation_start) begin P_in = rand_state(); rounds = 5'd6; end
    end
    permutation_start = 1'b0;
    chk("ign_pulses", 320'(pulses), 320'd1);
    chk("ign_falls", 320'(falls), 320'd1);
    chk("ign_lat", 320'(rdy_cyc), 320'd12);
    chk("ign_out", got, IV_OUT);
    @(negedge clk);
    issue(IV_IN, 5'd12);
    wait_ready(lat);
    chk("b2b_first", P_out, IV_OUT);
    p2 = rand_state();
    issue(p2, 5'd12);
    chk("b2b_accept", 320'(busy), 320'd1);
    wait_ready(lat);
    chk("b2b_lat", 320'(lat), 320'd12);
    chk("b2b_out", P_out, model(p2, 12));
    @(negedge clk);
    issue(IV_IN, 5'd12);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pout", P_out, '0);
    chk("arst_busy", 320'(busy), 320'd0);
    chk("arst_ready", 320'(permutation_ready), 320'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (permutation_ready) pulses++;
    end
    chk("arst_nopulse", 320'(pulses), 320'd0);
    @(negedge clk) rst_n = 1'b1;
    issue(IV_IN, 5'd12);
    wait_ready(lat);
    chk("arst_iv_lat", 320'(lat), 320'd12);
    chk("arst_iv_out", P_out, IV_OUT);
    for (int n = 0; n < 24; n++) begin
      p = rand_state();
      r = 5'($urandom_range(0, 31));
      @(negedge clk);
      issue(p, r);
      wait_ready(lat);
      chk($sformatf("rnd%0d_lat_r%0d", n, r), 320'(lat), 320'((r > 12) ? 12 : r));
      chk($sformatf("rnd%0d_out_r%0d", n, r), P_out, model(p, int'(r)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
